// File: rtl/os_discard_collector.sv
// ---------------------------------------------------------------------------
// os_discard_collector
//   Overlap-save output stage. Receives NFFT-sample IFFT frames, throws away
//   the first NB (circularly aliased) samples of each frame, stores the last
//   NB samples into one bank of a two-bank buffer and streams completed
//   blocks out over a valid/ready interface. Reception of the next frame can
//   proceed into the other bank while the downstream is stalling.
//
// Handshake: a sample moves on data_out in every cycle where valid_out and
//   ready_out are both 1. Once valid_out is raised, valid_out and data_out
//   stay unchanged until that handshake happens.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous, active-low reset
//   start_ifft     frame-start marker, qualified by valid_in_ifft
//   valid_in_ifft  data_in_ifft carries a sample this cycle
//   data_in_ifft   IFFT output sample (WN bits, passed through untouched)
//   ready_out      downstream ready
//   valid_out      data_out valid
//   data_out       kept sample
//   block_done     high on the handshake of the last sample of a block
//   frame_err      one-cycle pulse on overflow (frame dropped) or resync
//   dbg_in_state   input FSM state (IDLE/DISCARD/KEEP/DROP)
//   dbg_out_state  output FSM state (O_IDLE/O_RUN)
// ---------------------------------------------------------------------------
module os_discard_collector #(
  parameter int WN   = 16,
  parameter int NFFT = 32,
  parameter int NB   = NFFT / 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_ifft,
  input  logic          valid_in_ifft,
  input  logic [WN-1:0] data_in_ifft,
  input  logic          ready_out,
  output logic          valid_out,
  output logic [WN-1:0] data_out,
  output logic          block_done,
  output logic          frame_err,
  output logic [1:0]    dbg_in_state,
  output logic          dbg_out_state
);

  localparam int CW = $clog2(NFFT);
  localparam int AW = $clog2(NB);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_DISC = CW'(NB - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NFFT - 1);
  localparam logic [CW-1:0] RD_END   = CW'(NB);
  localparam logic [CW-1:0] OUT_LAST = CW'(NB - 1);

  typedef enum logic [1:0] {S_IDLE, S_DISCARD, S_KEEP, S_DROP} in_state_e;
  typedef enum logic       {O_IDLE, O_RUN} out_state_e;

  in_state_e       in_state_q, in_state_d;
  out_state_e      out_state_q, out_state_d;
  logic [CW-1:0]   in_cnt_q, in_cnt_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]      full_q, full_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic            frame_err_q, frame_err_d;
  logic            valid_out_q, valid_out_d;
  logic [WN-1:0]   data_out_q, data_out_d;
  logic [WN-1:0]   mem_q [2*NB];

  logic frame_start;
  logic wr_en;
  logic wr_fill;
  logic handshake;
  logic last_hs;
  logic rd_load;
  logic wr_bank_busy;

  assign frame_start = start_ifft & valid_in_ifft;
  assign handshake   = valid_out_q & ready_out;
  assign last_hs     = handshake && (out_cnt_q == OUT_LAST);
  // Fetch the next stored sample whenever the output register is free or
  // is being emptied this cycle; rd_ptr counts fetches, out_cnt handshakes.
  assign rd_load     = (out_state_q == O_RUN) && (rd_ptr_q != RD_END) &&
                       (!valid_out_q || ready_out);
  // A bank released this cycle is already free for a starting frame.
  assign wr_bank_busy = full_q[wr_bank_q] && !(last_hs && (rd_bank_q == wr_bank_q));

  // ---------------- state registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_state_q  <= S_IDLE;
      out_state_q <= O_IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      rd_ptr_q    <= '0;
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      frame_err_q <= 1'b0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      frame_err_q <= frame_err_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
    end
  end

  // Sample storage carries no reset: contents are only read after a write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{wr_bank_q, in_cnt_q[AW-1:0]}] <= data_in_ifft;
    end
  end

  // ---------------- input FSM: next state ----------------
  always_comb begin
    in_state_d = in_state_q;
    in_cnt_d   = in_cnt_q;
    if (valid_in_ifft) begin
      if (frame_start) begin
        // Any start is sample 0 of a new frame, whatever state we were in.
        in_cnt_d   = CNT_ONE;
        in_state_d = wr_bank_busy ? S_DROP : S_DISCARD;
      end else begin
        case (in_state_q)
          S_DISCARD: begin
            in_cnt_d = in_cnt_q + CNT_ONE;
            if (in_cnt_q == CNT_DISC) in_state_d = S_KEEP;
          end
          S_KEEP, S_DROP: begin
            if (in_cnt_q == CNT_LAST) begin
              in_cnt_d   = '0;
              in_state_d = S_IDLE;
            end else begin
              in_cnt_d = in_cnt_q + CNT_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- input FSM: outputs ----------------
  always_comb begin
    wr_en       = valid_in_ifft && !frame_start && (in_state_q == S_KEEP);
    wr_fill     = wr_en && (in_cnt_q == CNT_LAST);
    frame_err_d = frame_start && ((in_state_q != S_IDLE) || wr_bank_busy);
  end

  // ---------------- bank bookkeeping ----------------
  // Releasing the read bank and filling the write bank touch different banks.
  always_comb begin
    full_d = full_q;
    if (last_hs) full_d[rd_bank_q] = 1'b0;
    if (wr_fill) full_d[wr_bank_q] = 1'b1;
    wr_bank_d = wr_bank_q ^ wr_fill;
    rd_bank_d = rd_bank_q ^ last_hs;
  end

  // ---------------- output FSM: next state ----------------
  always_comb begin
    out_state_d = out_state_q;
    out_cnt_d   = out_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    case (out_state_q)
      O_IDLE: begin
        if (full_q[rd_bank_q]) begin
          out_state_d = O_RUN;
          out_cnt_d   = '0;
          rd_ptr_d    = '0;
        end
      end
      default: begin
        if (rd_load) rd_ptr_d = rd_ptr_q + CNT_ONE;
        if (last_hs) begin
          out_cnt_d   = '0;
          rd_ptr_d    = '0;
          // Uses the registered flag so a bank filled this same cycle keeps
          // the normal two-cycle fill-to-valid latency via O_IDLE.
          out_state_d = full_q[~rd_bank_q] ? O_RUN : O_IDLE;
        end else if (handshake) begin
          out_cnt_d = out_cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  // ---------------- output FSM: outputs ----------------
  always_comb begin
    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;
    if (handshake) valid_out_d = 1'b0;
    if (rd_load) begin
      valid_out_d = 1'b1;
      data_out_d  = mem_q[{rd_bank_q, rd_ptr_q[AW-1:0]}];
    end
  end

  assign valid_out     = valid_out_q;
  assign data_out      = data_out_q;
  assign block_done    = last_hs;
  assign frame_err     = frame_err_q;
  assign dbg_in_state  = in_state_q;
  assign dbg_out_state = out_state_q;

endmodule

// File: tb/tb_os_discard_collector.sv
// ---------------------------------------------------------------------------
// tb_os_discard_collector
//   Directed plus randomized stimulus for os_discard_collector. A reference
//   model, sampled on the falling clock edge, follows frames as sample
//   counts: every completed, non-dropped frame appends its second half to
//   exp_q; a frame is dropped when two completed blocks are still pending
//   output. Output handshakes pop exp_q and free pending blocks.
// ---------------------------------------------------------------------------
module tb_os_discard_collector;
  localparam int WN   = 16;
  localparam int NFFT = 32;
  localparam int NB   = NFFT / 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start_ifft    = 1'b0;
  logic          valid_in_ifft = 1'b0;
  logic [WN-1:0] data_in_ifft  = '0;
  logic          ready_out     = 1'b1;
  logic          valid_out;
  logic [WN-1:0] data_out;
  logic          block_done;
  logic          frame_err;
  logic [1:0]    dbg_in_state;
  logic          dbg_out_state;

  os_discard_collector #(.WN(WN), .NFFT(NFFT)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_ifft    (start_ifft),
    .valid_in_ifft (valid_in_ifft),
    .data_in_ifft  (data_in_ifft),
    .ready_out     (ready_out),
    .valid_out     (valid_out),
    .data_out      (data_out),
    .block_done    (block_done),
    .frame_err     (frame_err),
    .dbg_in_state  (dbg_in_state),
    .dbg_out_state (dbg_out_state)
  );

  int n_checks   = 0;
  int n_fail     = 0;
  int ready_mode = 0;   // 0: always 1, 1: toggle, 2: always 0, 3: random
  int hs_total   = 0;

  // ---------------- reference model state ----------------
  logic [WN-1:0] exp_q[$];
  bit            exp_last_q[$];
  logic [WN-1:0] kept_q[$];
  int            pending   = 0;
  int            n_in      = 0;
  bit            active    = 1'b0;
  bit            dropping  = 1'b0;
  bit            ferr_exp  = 1'b0;
  bit            stall_prev = 1'b0;
  logic [WN-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  always @(negedge clk or negedge rst) begin : monitor
    logic          hs;
    bit            last;
    logic [WN-1:0] exp_d;
    if (!rst) begin
      exp_q.delete();
      exp_last_q.delete();
      kept_q.delete();
      pending    = 0;
      n_in       = 0;
      active     = 1'b0;
      dropping   = 1'b0;
      ferr_exp   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(valid_out), 32'd1);
        check("hold_data", 32'(data_out), 32'(prev_data));
      end
      check("frame_err", 32'(frame_err), 32'(ferr_exp));

      hs   = valid_out && ready_out;
      last = 1'b0;
      if (hs) begin
        hs_total++;
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL spurious_out: observed data %0h, expected no output", data_out);
        end
        if (exp_q.size() != 0) begin
          exp_d = exp_q.pop_front();
          last  = exp_last_q.pop_front();
          check("data_out", 32'(data_out), 32'(exp_d));
        end
      end
      check("block_done", 32'(block_done), 32'(hs && last));
      if (hs && last) pending--;
      stall_prev = valid_out && !ready_out;
      prev_data  = data_out;

      // Input side: release above is seen before the overflow decision.
      ferr_exp = 1'b0;
      if (valid_in_ifft && start_ifft) begin
        ferr_exp = active || (pending == 2);
        dropping = (pending == 2);
        active   = 1'b1;
        n_in     = 1;
        kept_q.delete();
      end else if (valid_in_ifft && active) begin
        if (!dropping && n_in >= NB) kept_q.push_back(data_in_ifft);
        n_in++;
        if (n_in == NFFT) begin
          active = 1'b0;
          if (!dropping) begin
            for (int i = 0; i < NB; i++) begin
              exp_q.push_back(kept_q[i]);
              exp_last_q.push_back(i == NB - 1);
            end
            pending++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    case (ready_mode)
      0:       ready_out = 1'b1;
      1:       ready_out = ~ready_out;
      2:       ready_out = 1'b0;
      default: ready_out = 1'($urandom_range(0, 1));
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      start_ifft    = 1'b0;
      valid_in_ifft = 1'b0;
      data_in_ifft  = WN'($urandom);
      tick();
    end
  endtask

  // gap_mode 0: no gaps, 1: gap before every 3rd sample, 2: random gaps
  task automatic send_frame(input int base, input int nsamp, input int gap_mode);
    for (int i = 0; i < nsamp; i++) begin
      if ((gap_mode == 1 && (i % 3) == 2) ||
          (gap_mode == 2 && $urandom_range(0, 3) == 0)) idle(1);
      start_ifft    = (i == 0);
      valid_in_ifft = 1'b1;
      data_in_ifft  = WN'(base + i);
      tick();
    end
    start_ifft    = 1'b0;
    valid_in_ifft = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int cyc;
    cyc = 0;
    if (ready_mode == 2) ready_mode = 3;
    while (exp_q.size() != 0 && cyc < budget) begin
      idle(1);
      cyc++;
    end
    idle(4);
    check(tag, 32'(exp_q.size()), 32'd0);
    check("idle_valid_low", 32'(valid_out), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin : stim
    int base;
    int cyc;

    // Reset state
    #1;
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_block_done", 32'(block_done), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    // 1: single frame, full-rate output, fill-to-valid latency of 2 cycles
    ready_mode = 0;
    send_frame(1, NFFT, 0);
    idle(1);
    check("lat_cycle1_valid", 32'(valid_out), 32'd0);
    idle(1);
    check("lat_cycle2_valid", 32'(valid_out), 32'd1);
    check("lat_cycle2_data", 32'(data_out), 32'd17);
    wait_drain("t1_drain", 100);

    // 2: three back-to-back frames
    send_frame(1, NFFT, 0);
    send_frame(33, NFFT, 0);
    send_frame(65, NFFT, 0);
    wait_drain("t2_drain", 200);

    // 3: input gaps every 3rd cycle, toggling ready
    ready_mode = 1;
    send_frame(1, NFFT, 1);
    wait_drain("t3_drain", 200);

    // 4: downstream stalled across three frames; third one is dropped
    ready_mode = 2;
    send_frame(1, NFFT, 0);
    send_frame(33, NFFT, 0);
    send_frame(65, NFFT, 0);
    idle(3);
    check("t4_stalled_valid", 32'(valid_out), 32'd1);
    check("t4_stalled_data", 32'(data_out), 32'd17);
    ready_mode = 0;
    wait_drain("t4_drain", 200);

    // 5: resync part-way through a frame
    send_frame(1, 19, 0);
    send_frame(101, NFFT, 0);
    wait_drain("t5_drain", 200);

    // 6: asynchronous reset in the middle of draining a block
    ready_mode = 0;
    send_frame(1, NFFT, 0);
    base = hs_total;
    cyc  = 0;
    while (hs_total - base < 5 && cyc < 100) begin
      idle(1);
      cyc++;
    end
    check("t6_reach_out_cnt5", 32'(hs_total - base), 32'd5);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_valid", 32'(valid_out), 32'd0);
    check("t6_async_data", 32'(data_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);
    check("t6_post_rst_valid", 32'(valid_out), 32'd0);
    send_frame(1, NFFT, 0);
    wait_drain("t6_drain", 100);

    // 7: randomized frames, gaps, backpressure, stray samples and resyncs
    for (int k = 0; k < 16; k++) begin
      ready_mode = $urandom_range(0, 3);
      base = $urandom_range(0, 60000);
      if ($urandom_range(0, 4) == 0) begin
        send_frame(base, $urandom_range(2, NFFT - 1), $urandom_range(0, 2));
      end else begin
        send_frame(base, NFFT, $urandom_range(0, 2));
        if ($urandom_range(0, 3) == 0) begin
          valid_in_ifft = 1'b1;
          data_in_ifft  = WN'($urandom);
          tick();
          valid_in_ifft = 1'b0;
        end
      end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 12));
    end
    ready_mode = 3;
    wait_drain("t7_drain", 2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
